// File: rtl/bpred_pkg.sv
// Shared types, constants and the index fold for the pattern-history table.
package bpred_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned CTR_W_DEF = 2;
  localparam int unsigned CTR_MAX   = (1 << CTR_W_DEF) - 1;

  // Table index: word-aligned PC bits XORed with zero-extended history, masked to idx_w bits.
  function automatic logic [31:0] idx(input logic [31:0] pc, input logic [31:0] hist,
                                      input int unsigned idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return ((pc >> 2) ^ hist) & mask;
  endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// Saturating up/down counter next-state logic for the update read-modify-write path.
module bpred_sat_ctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] next_c
);

  localparam logic [CTR_W-1:0] MAX = {CTR_W{1'b1}};

  // Step toward the resolved direction, holding at either rail.
  always_comb begin
    next_c = ctr;
    if (taken) begin
      if (ctr != MAX) next_c = ctr + CTR_W'(1);
    end else begin
      if (ctr != '0) next_c = ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/bpred_pht.sv
// Pattern-history table: registered prediction port, commit update port,
// post-reset init sweep. Gshare indexing and GHR tracking under BPRED_GSHARE_EN.
module bpred_pht
  import bpred_pkg::*;
#(
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned CTR_W    = CTR_W_DEF,
  parameter int unsigned HIST_W   = 8,
  parameter int unsigned CTR_INIT = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              rd_valid,
  input  logic [31:0]       rd_pc,
  output logic              rd_ready,
  output logic              rd_resp_valid,
  output logic              rd_taken,
  output logic [CTR_W-1:0]  rd_ctr,
  output logic [HIST_W-1:0] rd_hist,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispredict
);

  localparam int unsigned      ENTRIES = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(ENTRIES - 1);

  logic [CTR_W-1:0] pht_q [ENTRIES];
  state_t           state_q;
  logic [IDX_W-1:0] sweep_q;

  logic             accept_c;
  logic             upd_en_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [IDX_W-1:0] upd_idx_c;
  logic [CTR_W-1:0] rd_rdata_c;
  logic [CTR_W-1:0] upd_rdata_c;
  logic [CTR_W-1:0] upd_next_c;

  assign accept_c = rd_valid && rd_ready;
  assign upd_en_c = upd_valid && (state_q == RUN);

`ifdef BPRED_GSHARE_EN
  logic [HIST_W-1:0] ghr_q;

  assign rd_idx_c  = IDX_W'(idx(rd_pc, 32'(ghr_q), IDX_W));
  assign upd_idx_c = IDX_W'(idx(upd_pc, 32'(upd_hist), IDX_W));

  // Speculative history: restore from commit on mispredict, else shift in each prediction.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ghr_q   <= '0;
      rd_hist <= '0;
    end else begin
      if (upd_en_c && upd_mispredict) ghr_q <= {upd_hist[HIST_W-2:0], upd_taken};
      else if (rd_resp_valid)         ghr_q <= {ghr_q[HIST_W-2:0], rd_taken};
      if (accept_c) rd_hist <= ghr_q;
    end
  end
`else
  logic unused_c;

  assign rd_idx_c  = IDX_W'(idx(rd_pc, 32'd0, IDX_W));
  assign upd_idx_c = IDX_W'(idx(upd_pc, 32'd0, IDX_W));
  assign rd_hist   = '0;
  assign unused_c  = ^{upd_hist, upd_mispredict};
`endif

  assign rd_rdata_c  = pht_q[rd_idx_c];
  assign upd_rdata_c = pht_q[upd_idx_c];

  bpred_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr    (upd_rdata_c),
    .taken  (upd_taken),
    .next_c (upd_next_c)
  );

  // Init sweep FSM and registered prediction response.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= INIT;
      sweep_q       <= '0;
      rd_ready      <= 1'b0;
      rd_resp_valid <= 1'b0;
      rd_taken      <= 1'b0;
      rd_ctr        <= '0;
    end else begin
      if (state_q == INIT) begin
        sweep_q <= sweep_q + IDX_W'(1);
        if (sweep_q == LAST) begin
          state_q  <= RUN;
          rd_ready <= 1'b1;
        end
      end
      rd_resp_valid <= accept_c;
      if (accept_c) begin
        rd_ctr   <= rd_rdata_c;
        rd_taken <= rd_rdata_c[CTR_W-1];
      end
    end
  end

  // Counter array: sweep writes during INIT, commit writes during RUN.
  always_ff @(posedge CLK) begin
    if (state_q == INIT)  pht_q[sweep_q]   <= CTR_W'(CTR_INIT);
    else if (upd_en_c)    pht_q[upd_idx_c] <= upd_next_c;
  end

endmodule

// File: tb/tb_bpred_pht.sv
// Bench for bpred_pht (default build; gshare checks enabled with BPRED_GSHARE_EN).
module tb_bpred_pht;
  import bpred_pkg::*;

  localparam int N = 1024;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_pc = '0;
  logic        rd_ready, rd_resp_valid, rd_taken;
  logic [1:0]  rd_ctr;
  logic [7:0]  rd_hist;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [7:0]  upd_hist = '0;
  logic        upd_taken = 1'b0;
  logic        upd_mispredict = 1'b0;

  bpred_pht #(.IDX_W(10), .CTR_W(2), .HIST_W(8), .CTR_INIT(0)) dut (
    .CLK(CLK), .RESET(RESET),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ready(rd_ready),
    .rd_resp_valid(rd_resp_valid), .rd_taken(rd_taken), .rd_ctr(rd_ctr), .rd_hist(rd_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model state: plain integer counters and history.
  int mdl [N];
  int m_ghr, m_cnt, m_rctr, m_rhist;
  bit m_ready, m_rv;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] pc, input int hist);
`ifdef BPRED_GSHARE_EN
    return int'(((pc >> 2) ^ 32'(hist)) % N);
`else
    return int'((pc >> 2) % N) + 0 * hist;
`endif
  endfunction

  // PC whose read index hits target given the model's current history.
  function automatic logic [31:0] pc_for(input int target);
`ifdef BPRED_GSHARE_EN
    return 32'(((target ^ m_ghr) % N) * 4);
`else
    return 32'(target * 4);
`endif
  endfunction

  task automatic idle();
    rd_valid = 0; upd_valid = 0; upd_mispredict = 0; upd_taken = 0;
  endtask

  // One clock: advance the model from the driven inputs, then compare outputs.
  task automatic step();
    bit acc;
    int g_n, ui;
    acc = rd_valid && m_ready;
    g_n = m_ghr;
`ifdef BPRED_GSHARE_EN
    if (upd_valid && m_ready && upd_mispredict) g_n = ((int'(upd_hist) * 2) + int'(upd_taken)) % 256;
    else if (m_rv) g_n = ((m_ghr * 2) + ((m_rctr > int'(CTR_MAX) / 2) ? 1 : 0)) % 256;
`endif
    if (acc) begin
      m_rctr  = mdl[midx(rd_pc, m_ghr)];
      m_rhist = m_ghr;
    end
    if (upd_valid && m_ready) begin
      ui = midx(upd_pc, int'(upd_hist));
      if (upd_taken) mdl[ui] = (mdl[ui] + 1 > int'(CTR_MAX)) ? int'(CTR_MAX) : mdl[ui] + 1;
      else           mdl[ui] = (mdl[ui] == 0) ? 0 : mdl[ui] - 1;
    end
    m_rv  = acc;
    m_ghr = g_n;
    @(posedge CLK); #1;
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == N) m_ready = 1;
    end
    chk("rd_ready", 32'(rd_ready), 32'(m_ready));
    chk("rd_resp_valid", 32'(rd_resp_valid), 32'(m_rv));
    if (m_rv) begin
      chk("rd_ctr", 32'(rd_ctr), 32'(m_rctr));
      chk("rd_taken", 32'(rd_taken), (m_rctr > int'(CTR_MAX) / 2) ? 32'd1 : 32'd0);
      chk("rd_hist", 32'(rd_hist), 32'(m_rhist));
    end
  endtask

  // Hold reset a few cycles, check reset values, release just after an edge.
  task automatic do_reset();
    idle();
    RESET = 0;
    for (int i = 0; i < N; i++) mdl[i] = 0;
    m_ghr = 0; m_cnt = 0; m_rctr = 0; m_rhist = 0; m_ready = 0; m_rv = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rd_ready", 32'(rd_ready), 32'd0);
    chk("rst_resp_valid", 32'(rd_resp_valid), 32'd0);
    chk("rst_rd_taken", 32'(rd_taken), 32'd0);
    chk("rst_rd_ctr", 32'(rd_ctr), 32'd0);
    chk("rst_rd_hist", 32'(rd_hist), 32'd0);
    RESET = 1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!rd_ready && n < 2000) begin
      step();
      n++;
    end
    chk(nm, 32'(n), 32'(N));
  endtask

  typedef struct {
    logic taken;
    int   exp_ctr;
    logic exp_taken;
  } sat_vec_t;

  initial begin
    sat_vec_t sat_tab[5];
    sat_tab[0] = '{1'b1, 1, 1'b0};
    sat_tab[1] = '{1'b1, 2, 1'b1};
    sat_tab[2] = '{1'b1, 3, 1'b1};
    sat_tab[3] = '{1'b1, 3, 1'b1};
    sat_tab[4] = '{1'b0, 2, 1'b1};

    // Reset sweep length and initial contents of every entry.
    do_reset();
    wait_ready("sweep_len");
    for (int i = 0; i < N; i++) begin
      rd_valid = 1; rd_pc = pc_for(i);
      step();
      chk("init_ctr", 32'(rd_ctr), 32'd0);
    end
    idle();
    step();

    // Saturation at pc 0x31C, history 0.
    for (int v = 0; v < 5; v++) begin
      upd_valid = 1; upd_pc = 32'h31C; upd_hist = 8'h00; upd_taken = sat_tab[v].taken;
      step();
      idle();
      rd_valid = 1; rd_pc = pc_for(32'h31C >> 2);
      step();
      idle();
      chk("sat_ctr", 32'(rd_ctr), 32'(sat_tab[v].exp_ctr));
      chk("sat_taken", 32'(rd_taken), 32'(sat_tab[v].exp_taken));
    end
    step();

`ifdef BPRED_GSHARE_EN
    // Gshare separation: update with hist 1 only affects the history-1 alias.
    upd_valid = 1; upd_pc = 32'h100; upd_hist = 8'h01; upd_taken = 1;
    step();
    upd_pc = 32'hFFC; upd_hist = 8'h00; upd_taken = 0; upd_mispredict = 1;
    step();
    idle();
    rd_valid = 1; rd_pc = 32'h100;
    step();
    chk("gs_hist0_ctr", 32'(rd_ctr), 32'd0);
    idle();
    upd_valid = 1; upd_pc = 32'hFFC; upd_hist = 8'h00; upd_taken = 1; upd_mispredict = 1;
    step();
    idle();
    rd_valid = 1; rd_pc = 32'h100;
    step();
    chk("gs_hist1_ctr", 32'(rd_ctr), 32'd1);
    chk("gs_hist1_hist", 32'(rd_hist), 32'h01);
    idle();
    step();

    // Mispredict restore wins over a same-cycle speculative shift.
    upd_valid = 1; upd_pc = 32'hFFC; upd_hist = 8'h52; upd_taken = 1; upd_mispredict = 1;
    step();
    idle();
    rd_valid = 1; rd_pc = 32'h500;
    step();
    chk("mp_spec_hist", 32'(rd_hist), 32'hA5);
    chk("mp_resp_valid", 32'(rd_resp_valid), 32'd1);
    idle();
    upd_valid = 1; upd_pc = 32'hFFC; upd_hist = 8'h3C; upd_taken = 1; upd_mispredict = 1;
    step();
    idle();
    rd_valid = 1; rd_pc = 32'h500;
    step();
    chk("mp_restore_hist", 32'(rd_hist), 32'h79);
    idle();
    step();
`endif

    // Same-index read and update: read sees the old value, next read the new one.
    upd_valid = 1; upd_pc = 32'h200; upd_hist = 8'h00; upd_taken = 1;
    step();
    idle();
    rd_valid = 1; rd_pc = pc_for(32'h80);
    upd_valid = 1; upd_pc = 32'h200; upd_hist = 8'h00; upd_taken = 1;
    step();
    chk("coll_old", 32'(rd_ctr), 32'd1);
    idle();
    rd_valid = 1; rd_pc = pc_for(32'h80);
    step();
    chk("coll_new", 32'(rd_ctr), 32'd2);
    idle();
    step();

    // Back-to-back updates to one index accumulate.
    for (int k = 0; k < 2; k++) begin
      upd_valid = 1; upd_pc = 32'h204; upd_hist = 8'h00; upd_taken = 1;
      step();
    end
    idle();
    rd_valid = 1; rd_pc = pc_for(32'h81);
    step();
    chk("b2b_ctr", 32'(rd_ctr), 32'd2);
    idle();

    // Randomised traffic on a small PC set to force collisions.
    for (int c = 0; c < 3000; c++) begin
      rd_valid       = ($urandom_range(0, 3) != 0);
      rd_pc          = 32'($urandom_range(0, 63) * 4);
      upd_valid      = ($urandom_range(0, 1) == 1);
      upd_pc         = 32'($urandom_range(0, 63) * 4);
      upd_hist       = 8'($urandom);
      upd_taken      = 1'($urandom);
      upd_mispredict = ($urandom_range(0, 7) == 0);
      step();
    end
    idle();
    step();

    // Reset mid-sweep: sweep restarts and updates during the sweep are dropped.
    do_reset();
    repeat (500) step();
    do_reset();
    rd_valid = 1; rd_pc = 32'h31C;
    upd_valid = 1; upd_pc = 32'h31C; upd_hist = 8'h00; upd_taken = 1;
    wait_ready("resweep_len");
    idle();
    rd_valid = 1; rd_pc = pc_for(32'h31C >> 2);
    step();
    chk("resweep_31c", 32'(rd_ctr), 32'd0);
    rd_pc = pc_for(32'h80);
    step();
    chk("resweep_200", 32'(rd_ctr), 32'd0);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
